// File: rtl/bloco_controle_pkg.sv
// Shared definitions for the bloco_controle Horner-rule controller:
// state encoding, datapath mux select codes, ULA op codes and the
// bundled control word produced by the output decoder.
package bloco_controle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_S3   = 3'd4,
        ST_S4   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Input mux M0: selects which external operand reaches mux0
    localparam logic [1:0] SEL0_K = 2'b00;
    localparam logic [1:0] SEL0_A = 2'b01;
    localparam logic [1:0] SEL0_B = 2'b10;
    localparam logic [1:0] SEL0_C = 2'b11;

    // Operand mux M1: ULA operand b
    localparam logic [1:0] SEL1_MUX0 = 2'b00;
    localparam logic [1:0] SEL1_X    = 2'b01;
    localparam logic [1:0] SEL1_S    = 2'b10;
    localparam logic [1:0] SEL1_H    = 2'b11;

    // Operand mux M2: ULA operand a
    localparam logic [1:0] SEL2_X    = 2'b00;
    localparam logic [1:0] SEL2_MUX0 = 2'b01;
    localparam logic [1:0] SEL2_S    = 2'b10;
    localparam logic [1:0] SEL2_H    = 2'b11;

    // ULA operation (multiply keeps the low 16 bits)
    localparam logic ULA_ADD = 1'b0;
    localparam logic ULA_MUL = 1'b1;

    // Every control line the controller drives, decoded from state
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       lx;
        logic       lh;
        logic       ls;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
    } ctrl_t;

endpackage

// File: rtl/bloco_controle_if.sv
// Host handshake plus datapath control lines of bloco_controle.
// BLOCO_CONTROLE_ACCUM_EN adds the acc request line.
interface bloco_controle_if;

    logic       start;
`ifdef BLOCO_CONTROLE_ACCUM_EN
    logic       acc;
`endif
    logic       busy;
    logic       done;
    logic       LX;
    logic       LH;
    logic       LS;
    logic [1:0] M0;
    logic [1:0] M1;
    logic [1:0] M2;
    logic       H;

    // Controller side
    modport master (
        input  start,
`ifdef BLOCO_CONTROLE_ACCUM_EN
        input  acc,
`endif
        output busy, done, LX, LH, LS, M0, M1, M2, H
    );

    // Host / datapath side
    modport slave (
        output start,
`ifdef BLOCO_CONTROLE_ACCUM_EN
        output acc,
`endif
        input  busy, done, LX, LH, LS, M0, M1, M2, H
    );

endinterface

// File: rtl/bloco_controle_decodificador.sv
// decodificador_controle: Moore output decoder. Maps the FSM state (and
// the accumulate flag latched for the current run) to every control line.
module decodificador_controle
    import bloco_controle_pkg::*;
(
    input  state_t state,
    input  logic   acc_run,
    output ctrl_t  ctrl
);

    // Decode state into control lines; unlisted lines stay at 0
    always_comb begin
        // NOTE: the all-zero default before the case keeps every field
        // assigned on every path, so no latch is inferred.
        ctrl = '0;
        unique case (state)
            ST_LOAD: begin
                ctrl.busy = 1'b1;
                ctrl.lx   = 1'b1;
            end
            ST_S1: begin  // H <= A * X
                ctrl.busy = 1'b1;
                ctrl.m0   = SEL0_A;
                ctrl.m1   = SEL1_MUX0;
                ctrl.m2   = SEL2_X;
                ctrl.h    = ULA_MUL;
                ctrl.lh   = 1'b1;
            end
            ST_S2: begin  // H <= H + B
                ctrl.busy = 1'b1;
                ctrl.m0   = SEL0_B;
                ctrl.m1   = SEL1_MUX0;
                ctrl.m2   = SEL2_H;
                ctrl.h    = ULA_ADD;
                ctrl.lh   = 1'b1;
            end
            ST_S3: begin  // H <= H * X
                ctrl.busy = 1'b1;
                ctrl.m1   = SEL1_X;
                ctrl.m2   = SEL2_H;
                ctrl.h    = ULA_MUL;
                ctrl.lh   = 1'b1;
            end
            ST_S4: begin  // S <= H + C, or S <= S + H when accumulating
                ctrl.busy = 1'b1;
                ctrl.m0   = SEL0_C;
                ctrl.m1   = acc_run ? SEL1_H : SEL1_MUX0;
                ctrl.m2   = acc_run ? SEL2_S : SEL2_H;
                ctrl.h    = ULA_ADD;
                ctrl.ls   = 1'b1;
            end
            ST_DONE: begin
                ctrl.done = 1'b1;
            end
            default: ;    // IDLE: everything low
        endcase
    end

endmodule

// File: rtl/bloco_controle.sv
// bloco_controle: Moore FSM sequencing the 16-bit datapath to evaluate
// Y = A*X^2 + B*X + C by Horner's rule (X = K). Optional feature macro:
// BLOCO_CONTROLE_ACCUM_EN (adds acc; latched acc=1 makes S <= S + A*X^2 + B*X).
module bloco_controle
    import bloco_controle_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    bloco_controle_if.master  bus
);

    state_t state_q, state_d;
    logic   acc_run;
    ctrl_t  ctrl;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples its pre-edge value regardless of block ordering.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: a fixed walk LOAD..DONE once start is seen in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = ST_S4;
            ST_S4:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef BLOCO_CONTROLE_ACCUM_EN
    logic acc_q, acc_d;

    // Capture acc alongside start so it stays fixed for the whole run
    always_comb begin
        acc_d = acc_q;
        if (state_q == ST_IDLE && bus.start) acc_d = bus.acc;
    end

    // Latched accumulate flag
    always_ff @(posedge clk) begin
        if (rst) acc_q <= 1'b0;
        else     acc_q <= acc_d;
    end

    assign acc_run = acc_q;
`else
    assign acc_run = 1'b0;
`endif

    decodificador_controle u_decodificador (
        .state   (state_q),
        .acc_run (acc_run),
        .ctrl    (ctrl)
    );

    // Output drive: decoded control word onto the interface
    always_comb begin
        bus.busy = ctrl.busy;
        bus.done = ctrl.done;
        bus.LX   = ctrl.lx;
        bus.LH   = ctrl.lh;
        bus.LS   = ctrl.ls;
        bus.M0   = ctrl.m0;
        bus.M1   = ctrl.m1;
        bus.M2   = ctrl.m2;
        bus.H    = ctrl.h;
    end

endmodule

// File: tb/tb_bloco_controle.sv
// Testbench for bloco_controle. A small datapath (registers X/H/S, muxes,
// ULA) obeys the controller's lines; results are compared against the
// polynomial evaluated directly, and control lines against a per-cycle table.
module tb_bloco_controle;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bloco_controle_if bus ();

    bloco_controle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // External operands and datapath registers
    logic [15:0] a_in, b_in, c_in, k_in;
    logic [15:0] x_r, h_r, s_r;
    logic [15:0] mux0, opa, opb, ula;
    logic [15:0] s_model;   // expected content of S after the last completed run

    // Datapath: muxes and ULA as described by the select encodings
    always_comb begin
        case (bus.M0)
            2'b00:   mux0 = k_in;
            2'b01:   mux0 = a_in;
            2'b10:   mux0 = b_in;
            default: mux0 = c_in;
        endcase
        case (bus.M1)
            2'b00:   opb = mux0;
            2'b01:   opb = x_r;
            2'b10:   opb = s_r;
            default: opb = h_r;
        endcase
        case (bus.M2)
            2'b00:   opa = x_r;
            2'b01:   opa = mux0;
            2'b10:   opa = s_r;
            default: opa = h_r;
        endcase
        ula = bus.H ? 16'(opa * opb) : 16'(opa + opb);
    end

    // Datapath registers
    always @(posedge clk) begin
        if (bus.LX) x_r <= k_in;
        if (bus.LH) h_r <= ula;
        if (bus.LS) s_r <= ula;
    end

    // Observed control word {busy,done,LX,LH,LS,M0,M1,M2,H}
    function automatic logic [11:0] obs();
        return {bus.busy, bus.done, bus.LX, bus.LH, bus.LS,
                bus.M0, bus.M1, bus.M2, bus.H};
    endfunction

    // Expected control word by cycle offset after the start edge
    function automatic logic [11:0] exp_ctrl(input int off, input bit acc);
        case (off)
            1: return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
            2: return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1};
            3: return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b11, 1'b0};
            4: return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b11, 1'b1};
            5: return acc ? {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 2'b10, 1'b0}
                          : {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b11, 1'b0};
            6: return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
            default: return 12'h000;
        endcase
    endfunction

    // Reference: Y = A*K^2 + B*K + C (mod 2^16), or S + A*K^2 + B*K when accumulating
    function automatic logic [15:0] poly(input logic [15:0] a, b, c, k, s_prev, input bit acc);
        logic [15:0] sq, ax2, bx;
        sq  = k * k;
        ax2 = a * sq;
        bx  = b * k;
        return acc ? 16'(s_prev + ax2 + bx) : 16'(ax2 + bx + c);
    endfunction

    // One evaluation: idle cycle, start pulse, per-cycle control check, result check
    task automatic do_run(input logic [15:0] a, b, c, k, input bit acc_req,
                          input bit poke_start, input string name);
        bit          acc_eff;
        logic [15:0] y_exp;
        acc_eff = 1'b0;
`ifdef BLOCO_CONTROLE_ACCUM_EN
        acc_eff = acc_req;
`endif
        @(posedge clk); #1;
        a_in = a; b_in = b; c_in = c; k_in = k;
        bus.start = 1'b1;
`ifdef BLOCO_CONTROLE_ACCUM_EN
        bus.acc = acc_req;
`endif
        y_exp = poly(a, b, c, k, s_model, acc_eff);
        for (int off = 1; off <= 6; off++) begin
            @(posedge clk); #1;
            if (off == 1) bus.start = 1'b0;
            if (poke_start && off == 3) bus.start = 1'b1;
            if (poke_start && off == 4) bus.start = 1'b0;
            checks++;
            if (obs() !== exp_ctrl(off, acc_eff)) begin
                failures++;
                $display("FAIL %s ctrl off=%0d got=%03h want=%03h", name, off, obs(), exp_ctrl(off, acc_eff));
            end
        end
        checks++;
        if (s_r !== y_exp) begin
            failures++;
            $display("FAIL %s result got=%04h want=%04h", name, s_r, y_exp);
        end
        s_model = y_exp;
        @(posedge clk); #1;
        checks++;
        if (obs() !== 12'h000) begin
            failures++;
            $display("FAIL %s idle_after got=%03h want=000", name, obs());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
`ifdef BLOCO_CONTROLE_ACCUM_EN
        bus.acc = 1'b0;
`endif
        a_in = '0; b_in = '0; c_in = '0; k_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%03h want=000", obs());
        end
        bus.start = 1'b1;               // rst outranks start
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority busy got=%b want=0", bus.busy);
        end
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_run(16'd2, 16'd3, 16'd4, 16'd5, 1'b0, 1'b0, "basic");   // 69
    endtask

    task automatic test_wrap();
        do_run(16'h0100, 16'h0001, 16'h0000, 16'h0100, 1'b0, 1'b0, "wrap");
        checks++;
        if (s_r !== 16'h0100) begin
            failures++;
            $display("FAIL wrap_const got=%04h want=0100", s_r);
        end
    endtask

    task automatic test_zero();
        do_run(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, "zero");
    endtask

    task automatic test_start_ignored();
        do_run(16'd7, 16'd11, 16'd13, 16'd3, 1'b0, 1'b1, "start_ignored");
        repeat (7) begin
            @(posedge clk); #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL start_ignored restart busy=%b done=%b want 0/0", bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s_before;
        s_before = s_model;
        @(posedge clk); #1;
        a_in = 16'd9; b_in = 16'd8; c_in = 16'd7; k_in = 16'd6;
        bus.start = 1'b1;
        repeat (3) begin @(posedge clk); #1; bus.start = 1'b0; end   // now in S2
        checks++;
        if (obs() !== exp_ctrl(3, 1'b0)) begin
            failures++;
            $display("FAIL rst_mid reach_s2 got=%03h want=%03h", obs(), exp_ctrl(3, 1'b0));
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (obs() !== 12'h000) begin
            failures++;
            $display("FAIL rst_mid outputs got=%03h want=000", obs());
        end
        checks++;
        if (s_r !== s_before) begin
            failures++;
            $display("FAIL rst_mid s_kept got=%04h want=%04h", s_r, s_before);
        end
        // Reset landing on the S4 edge: S still takes the new value
        @(posedge clk); #1;
        bus.start = 1'b1;
        repeat (5) begin @(posedge clk); #1; bus.start = 1'b0; end   // now in S4
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_model = poly(16'd9, 16'd8, 16'd7, 16'd6, s_model, 1'b0);
        checks++;
        if (s_r !== s_model || obs() !== 12'h000) begin
            failures++;
            $display("FAIL rst_at_s4 s=%04h ctrl=%03h want s=%04h ctrl=000", s_r, obs(), s_model);
        end
    endtask

    task automatic test_back_to_back();
        int done_cycles[$];
        int waited;
        logic [15:0] y_exp;
        @(posedge clk); #1;
        a_in = 16'd5; b_in = 16'hFFFF; c_in = 16'd1; k_in = 16'd300;
        y_exp = poly(a_in, b_in, c_in, k_in, s_model, 1'b0);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                done_cycles.push_back(cyc);
                checks++;
                if (s_r !== y_exp) begin
                    failures++;
                    $display("FAIL b2b result cyc=%0d got=%04h want=%04h", cyc, s_r, y_exp);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (done_cycles.size() != 4) begin
            failures++;
            $display("FAIL b2b done_count got=%0d want=4", done_cycles.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (done_cycles[i] != 6 + 7 * i) begin
                    failures++;
                    $display("FAIL b2b done_cycle[%0d] got=%0d want=%0d", i, done_cycles[i], 6 + 7 * i);
                end
            end
        end
        waited = 0;
        while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && waited < 12) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL b2b drain timeout busy=%b done=%b", bus.busy, bus.done);
        end
        s_model = y_exp;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_run(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)), 1'b0, "random");
        end
    endtask

`ifdef BLOCO_CONTROLE_ACCUM_EN
    task automatic test_accum();
        do_run(16'd0, 16'd1, 16'd9, 16'd2, 1'b0, 1'b0, "accum0");   // 11
        do_run(16'd0, 16'd1, 16'd9, 16'd2, 1'b1, 1'b0, "accum1");   // 13
        do_run(16'd0, 16'd1, 16'd9, 16'd2, 1'b1, 1'b0, "accum2");   // 15
        checks++;
        if (s_r !== 16'd15) begin
            failures++;
            $display("FAIL accum_const got=%0d want=15", s_r);
        end
    endtask
`endif

    initial begin
        s_model = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
`ifdef BLOCO_CONTROLE_ACCUM_EN
        test_accum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
